// File: rtl/lib_arbiter_pkg.sv
// Shared types and constants for the pixel-side arbiter handshake.
// Holds the per-pixel state encoding and the refractory counter sizing helper.
package lib_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      ACK     = 2'd2,
      REFRACT = 2'd3
   } pix_state_t;

   localparam int unsigned REFRACT_CYC_DEF = 4;

   // Width able to hold REFRACT_CYC-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned cyc);
      return (cyc > 2) ? $clog2(cyc) : 1;
   endfunction

endpackage

// File: rtl/pixel_req_cell.sv
// One pixel: request FSM, latched polarity, refractory hold-off and drop/grant-error strobes.
// The refractory counter exists only when PIXEL_REFRACTORY_EN is defined.
module pixel_req_cell
   import lib_arbiter_pkg::*;
#(
   parameter int unsigned REFRACT_CYC = REFRACT_CYC_DEF
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_evt,
   input  logic i_evt_pol,
   input  logic i_gnt,
   output logic o_req,
   output logic o_pol,
   output logic o_active,
   output logic o_drop,
   output logic o_gnt_err
);

   pix_state_t r_state;
   pix_state_t w_state_nxt;
   logic       r_pol;
   logic       w_pol_nxt;

`ifdef PIXEL_REFRACTORY_EN
   localparam int unsigned CntW = cnt_width(REFRACT_CYC);

   logic [CntW-1:0] r_cnt;
   logic [CntW-1:0] w_cnt_nxt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_cnt <= '0;
      else       r_cnt <= w_cnt_nxt;
   end
`else
   logic w_unused_refract;
   assign w_unused_refract = (REFRACT_CYC != 0);
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_pol   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pol   <= w_pol_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pol_nxt   = r_pol;
      o_drop      = 1'b0;
      o_gnt_err   = 1'b0;
`ifdef PIXEL_REFRACTORY_EN
      w_cnt_nxt   = r_cnt;
`endif
      case (r_state)
         IDLE: begin
            o_gnt_err = i_gnt;
            if (i_evt) begin
               w_state_nxt = REQ;
               w_pol_nxt   = i_evt_pol;
            end
         end
         // A grant wins over a same-cycle event; the event is counted as dropped.
         REQ: begin
            o_drop = i_evt;
            if (i_gnt) w_state_nxt = ACK;
         end
         ACK: begin
            o_drop = i_evt;
            if (!i_gnt) begin
`ifdef PIXEL_REFRACTORY_EN
               if (REFRACT_CYC == 0) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = REFRACT;
                  w_cnt_nxt   = CntW'(REFRACT_CYC - 1);
               end
`else
               w_state_nxt = IDLE;
`endif
            end
         end
         REFRACT: begin
            o_drop    = i_evt;
            o_gnt_err = i_gnt;
`ifdef PIXEL_REFRACTORY_EN
            if (r_cnt == '0) w_state_nxt = IDLE;
            else             w_cnt_nxt   = r_cnt - 1'b1;
`else
            w_state_nxt = IDLE;
`endif
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign o_req    = (r_state == REQ);
   assign o_pol    = r_pol;
   assign o_active = (r_state != IDLE);

endmodule

// File: rtl/pixel_event_requester.sv
// Pixel-array side of the req/gnt handshake: one request cell per pixel plus shared readout.
// Refractory hold-off is built only when PIXEL_REFRACTORY_EN is defined.
module pixel_event_requester
   import lib_arbiter_pkg::*;
#(
   parameter int unsigned Lvl_ROWS    = 2,
   parameter int unsigned Lvl_COLS    = 2,
   parameter int unsigned REFRACT_CYC = REFRACT_CYC_DEF,
   parameter int unsigned DROP_W      = 16
) (
   input  logic                               clk_i,
   input  logic                               reset_i,
   input  logic [Lvl_ROWS-1:0][Lvl_COLS-1:0]  evt_i,
   input  logic [Lvl_ROWS-1:0][Lvl_COLS-1:0]  evt_pol_i,
   input  logic [Lvl_ROWS-1:0][Lvl_COLS-1:0]  gnt_i,
   output logic [Lvl_ROWS-1:0][Lvl_COLS-1:0]  req_o,
   output logic                               pol_o,
   output logic                               busy_o,
   output logic [DROP_W-1:0]                  drop_cnt_o,
   output logic                               proto_err_o
);

   localparam int unsigned NPix = Lvl_ROWS * Lvl_COLS;
   localparam int unsigned SumW = $clog2(NPix + 1);
   localparam int unsigned AccW = ((DROP_W > SumW) ? DROP_W : SumW) + 1;

   logic [Lvl_ROWS-1:0][Lvl_COLS-1:0] w_pol;
   logic [Lvl_ROWS-1:0][Lvl_COLS-1:0] w_active;
   logic [Lvl_ROWS-1:0][Lvl_COLS-1:0] w_drop;
   logic [Lvl_ROWS-1:0][Lvl_COLS-1:0] w_gnt_err;
   logic [NPix-1:0]                   w_drop_flat;
   logic [SumW-1:0]                   w_drop_num;
   logic [AccW-1:0]                   w_drop_sum;
   logic [DROP_W-1:0]                 r_drop_cnt;
   logic                              r_busy;
   logic                              r_proto_err;

   for (genvar gr = 0; gr < Lvl_ROWS; gr++) begin : g_row
      for (genvar gc = 0; gc < Lvl_COLS; gc++) begin : g_col
         pixel_req_cell #(
            .REFRACT_CYC (REFRACT_CYC)
         ) u_cell (
            .i_clk     (clk_i),
            .i_rst     (reset_i),
            .i_evt     (evt_i[gr][gc]),
            .i_evt_pol (evt_pol_i[gr][gc]),
            .i_gnt     (gnt_i[gr][gc]),
            .o_req     (req_o[gr][gc]),
            .o_pol     (w_pol[gr][gc]),
            .o_active  (w_active[gr][gc]),
            .o_drop    (w_drop[gr][gc]),
            .o_gnt_err (w_gnt_err[gr][gc])
         );
      end
   end

   assign w_drop_flat = w_drop;

   always_comb begin
      w_drop_num = '0;
      for (int k = 0; k < NPix; k++) begin
         w_drop_num = w_drop_num + SumW'(w_drop_flat[k]);
      end
   end

   // Extra headroom bit(s) let a single add detect overflow for saturation.
   assign w_drop_sum = AccW'(r_drop_cnt) + AccW'(w_drop_num);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_drop_cnt  <= '0;
         r_busy      <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         r_drop_cnt  <= (w_drop_sum[AccW-1:DROP_W] != '0) ? '1 : w_drop_sum[DROP_W-1:0];
         r_busy      <= |w_active;
         r_proto_err <= r_proto_err | (|w_gnt_err);
      end
   end

   assign pol_o       = |(gnt_i & w_pol);
   assign busy_o      = r_busy;
   assign drop_cnt_o  = r_drop_cnt;
   assign proto_err_o = r_proto_err;

endmodule

// File: tb/tb_pixel_event_requester.sv
// Self-checking bench for pixel_event_requester: per-cycle vector table through a scoreboard
// queue, a DROP_W=2 instance for saturation, and a hand-written mid-handshake reset.
module tb_pixel_event_requester;

   typedef struct {
      logic [3:0]  evt;
      logic [3:0]  pol;
      logic [3:0]  gnt;
      logic [3:0]  req;
      logic        polo;
      logic        busy;
      int unsigned drop;
      logic        err;
   } vec_t;

`ifdef PIXEL_REFRACTORY_EN
   localparam int unsigned Tail = 5;
`else
   localparam int unsigned Tail = 1;
`endif

   vec_t vecs[$];
   vec_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   logic            clk = 1'b0;
   logic            reset_i;
   logic [1:0][1:0] evt;
   logic [1:0][1:0] pol;
   logic [1:0][1:0] gnt;
   logic [1:0][1:0] req;
   logic [1:0][1:0] req_s;
   logic            polo;
   logic            polo_s;
   logic            busy;
   logic            busy_s;
   logic            err;
   logic            err_s;
   logic [15:0]     drop;
   logic [1:0]      drop_s;

   always #5 clk = ~clk;

   pixel_event_requester #(
      .Lvl_ROWS    (2),
      .Lvl_COLS    (2),
      .REFRACT_CYC (4),
      .DROP_W      (16)
   ) u_dut (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .evt_i       (evt),
      .evt_pol_i   (pol),
      .gnt_i       (gnt),
      .req_o       (req),
      .pol_o       (polo),
      .busy_o      (busy),
      .drop_cnt_o  (drop),
      .proto_err_o (err)
   );

   pixel_event_requester #(
      .Lvl_ROWS    (2),
      .Lvl_COLS    (2),
      .REFRACT_CYC (4),
      .DROP_W      (2)
   ) u_dut_sat (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .evt_i       (evt),
      .evt_pol_i   (pol),
      .gnt_i       (gnt),
      .req_o       (req_s),
      .pol_o       (polo_s),
      .busy_o      (busy_s),
      .drop_cnt_o  (drop_s),
      .proto_err_o (err_s)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic [3:0] e, input logic [3:0] p, input logic [3:0] g,
                               input logic [3:0] r, input logic po, input logic b,
                               input int unsigned d, input logic er);
      vec_t v;
      v.evt = e; v.pol = p; v.gnt = g; v.req = r;
      v.polo = po; v.busy = b; v.drop = d; v.err = er;
      vecs.push_back(v);
   endfunction

   // Idle cycles after the last grant release until busy_o falls.
   function automatic void add_tail(input int unsigned d);
      for (int k = 0; k < Tail; k++) add(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, d, 1'b0);
      add(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, d, 1'b0);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec_t v;
      vec_t e;
      int unsigned sat;

      // evt, pol, gnt | req, pol_o, busy, drop, err
      // Pixel [0][1] handshake and grant-release timing
      add(4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 0, 1'b0);
      add(4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b0, 0, 1'b0);
      add(4'b0000, 4'b0000, 4'b0010, 4'b0010, 1'b1, 1'b1, 0, 1'b0);
      add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 0, 1'b0);
`ifdef PIXEL_REFRACTORY_EN
      add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 0, 1'b0);
      add(4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 0, 1'b0);
      add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1, 1'b0);
      add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1, 1'b0);
      add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1, 1'b0);
      add(4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 1, 1'b0);
      add(4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b0, 1, 1'b0);
      add(4'b0000, 4'b0000, 4'b0010, 4'b0010, 1'b1, 1'b1, 1, 1'b0);
      add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1, 1'b0);
`else
      add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 0, 1'b0);
      add(4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 0, 1'b0);
      add(4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b0, 0, 1'b0);
      add(4'b0000, 4'b0000, 4'b0010, 4'b0010, 1'b1, 1'b1, 0, 1'b0);
      add(4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 0, 1'b0);
`endif
      add_tail(1);
      // All four pixels fire together; round-robin grants 00, 01, 10, 11
      add(4'b1111, 4'b0101, 4'b0000, 4'b0000, 1'b0, 1'b0, 1, 1'b0);
      add(4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b0, 1, 1'b0);
      add(4'b0000, 4'b0000, 4'b0001, 4'b1111, 1'b1, 1'b1, 1, 1'b0);
      add(4'b0000, 4'b0000, 4'b0010, 4'b1110, 1'b0, 1'b1, 1, 1'b0);
      add(4'b0000, 4'b0000, 4'b0100, 4'b1100, 1'b1, 1'b1, 1, 1'b0);
      add(4'b0000, 4'b0000, 4'b1000, 4'b1000, 1'b0, 1'b1, 1, 1'b0);
      add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1, 1'b0);
      add_tail(1);
      // Event coincident with grant on [1][1]: grant taken, event dropped, polarity kept
      add(4'b1000, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1, 1'b0);
      add(4'b0000, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b0, 1, 1'b0);
      add(4'b1000, 4'b0000, 4'b1000, 4'b1000, 1'b1, 1'b1, 1, 1'b0);
      add(4'b0000, 4'b0000, 4'b1000, 4'b0000, 1'b1, 1'b1, 2, 1'b0);
      add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2, 1'b0);
      add_tail(2);
      // Four drops in one cycle: saturates the DROP_W=2 instance
      add(4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2, 1'b0);
      add(4'b1111, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b0, 2, 1'b0);
      add(4'b0000, 4'b0000, 4'b0001, 4'b1111, 1'b0, 1'b1, 6, 1'b0);
      add(4'b0000, 4'b0000, 4'b0010, 4'b1110, 1'b0, 1'b1, 6, 1'b0);
      add(4'b0000, 4'b0000, 4'b0100, 4'b1100, 1'b0, 1'b1, 6, 1'b0);
      add(4'b0000, 4'b0000, 4'b1000, 4'b1000, 1'b0, 1'b1, 6, 1'b0);
      add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 6, 1'b0);
      add_tail(6);
      // Grant to an idle pixel: ignored, sticky protocol error
      add(4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0, 6, 1'b0);
      add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 6, 1'b1);
      add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 6, 1'b1);
      add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 6, 1'b1);

      // Reset values, with inputs held active during reset
      reset_i = 1'b1;
      evt = 4'b1111;
      pol = 4'b1111;
      gnt = 4'b1111;
      repeat (2) @(negedge clk);
      chk("rst req", 32'(req), 32'h0);
      chk("rst pol_o", 32'(polo), 32'h0);
      chk("rst busy", 32'(busy), 32'h0);
      chk("rst drop", 32'(drop), 32'h0);
      chk("rst err", 32'(err), 32'h0);
      evt = 4'b0000;
      pol = 4'b0000;
      gnt = 4'b0000;
      reset_i = 1'b0;

      foreach (vecs[i]) begin
         v = vecs[i];
         @(posedge clk);
         #1;
         evt = v.evt;
         pol = v.pol;
         gnt = v.gnt;
         exp_q.push_back(v);
         @(negedge clk);
         e = exp_q.pop_front();
         sat = (e.drop > 3) ? 3 : e.drop;
         chk($sformatf("v%0d req", i), 32'(req), 32'(e.req));
         chk($sformatf("v%0d pol_o", i), 32'(polo), 32'(e.polo));
         chk($sformatf("v%0d busy", i), 32'(busy), 32'(e.busy));
         chk($sformatf("v%0d drop", i), 32'(drop), e.drop);
         chk($sformatf("v%0d err", i), 32'(err), 32'(e.err));
         chk($sformatf("v%0d sat_drop", i), 32'(drop_s), sat);
         chk($sformatf("v%0d sat_err", i), 32'(err_s), 32'(e.err));
      end
      chk("sb_empty", exp_q.size(), 0);

      // Reset while pixel [0][0] is requesting: req_o falls without a clock edge
      @(posedge clk);
      #1;
      evt = 4'b0001;
      pol = 4'b0001;
      @(posedge clk);
      #1;
      evt = 4'b0000;
      pol = 4'b0000;
      @(negedge clk);
      chk("pre_rst req", 32'(req), 32'h1);
      #2;
      reset_i = 1'b1;
      #1;
      chk("async_rst req", 32'(req), 32'h0);
      chk("async_rst drop", 32'(drop), 32'h0);
      chk("async_rst err", 32'(err), 32'h0);
      chk("async_rst busy", 32'(busy), 32'h0);
      @(negedge clk);
      reset_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_rst req", 32'(req), 32'h0);
      chk("post_rst busy", 32'(busy), 32'h0);
      chk("post_rst drop", 32'(drop), 32'h0);
      chk("post_rst sat_drop", 32'(drop_s), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
